fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage pipeline: holds the PC, drives the instruction-memory read address and
//   registers the returned 16-bit instruction into the IF/ID pipeline register for decode.
//   Sits directly upstream of InstructionMemory: imem_addr -> ReadAddress, Instruction -> imem_instr.
//   Handles hazard-unit stalls, branch redirects/flushes and a HALT opcode (4'hF).
// PARAMETERS
//   RESET_PC   16'h0000  PC value loaded on reset
//   PC_STEP    2         PC increment per fetch (instructions are 16-bit, byte-addressed)
//   NOP_INSTR  16'h0000  instruction injected into IF/ID on flush/bubble
//   HALT_OP    4'hF      opcode (instr[15:12]) that stops sequential fetch
// PORTS
//   clk            in   1   single clock, all state updates on posedge
//   rst            in   1   asynchronous, active-low reset
//   stall          in   1   hazard unit: hold PC and IF/ID contents
//   flush          in   1   squash IF/ID to NOP_INSTR next edge (PC still advances)
//   branch_taken   in   1   redirect from EX: load PC with branch_target
//   branch_target  in   16  redirect address (bit 0 forced to 0)
//   imem_instr     in   16  instruction read combinationally at imem_addr
//   imem_addr      out  16  current PC (combinational copy of PC register)
//   ifid_instr     out  16  registered instruction for decode
//   ifid_pc_plus   out  16  registered PC+PC_STEP of that instruction (link/branch base)
//   ifid_valid     out  1   1 = ifid_instr is a real fetched instruction
//   halted         out  1   1 while FSM in HALT
// BEHAVIOUR
//   Reset (rst=0, async): PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus=0, ifid_valid=0,
//     FSM=RUN, halted=0. Reset mid-operation discards everything; first fetch after release at RESET_PC.
//   FSM states: RUN, HALT. Per posedge, priority branch_taken > stall > flush > normal:
//   RUN, branch_taken=1: PC<=branch_target&16'hFFFE; IF/ID<=NOP, valid=0 (wrong-path squash).
//     Overrides stall and flush in the same cycle.
//   RUN, stall=1 (no branch): PC and all ifid_* hold. flush with stall: stall wins, hold.
//   RUN, flush=1 (no branch, no stall): PC<=PC+PC_STEP; IF/ID<=NOP, valid=0.
//   RUN, normal: ifid_instr<=imem_instr; ifid_pc_plus<=PC+PC_STEP; valid<=1; PC<=PC+PC_STEP.
//     If imem_instr[15:12]==HALT_OP: instruction still registered (valid=1), PC holds at the HALT
//     address (not incremented), FSM->HALT.
//   HALT: halted=1; PC holds; IF/ID<=NOP, valid=0 each non-stalled cycle (bubbles).
//     branch_taken=1 (HALT was wrong-path): PC<=target, FSM->RUN, halted=0 next cycle.
//     Only reset or branch_taken leave HALT; stall/flush have no other effect in HALT.
//   Latency: instruction at PC appears on ifid_instr one cycle after PC drives imem_addr.
//   Arithmetic: PC+PC_STEP is 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000, no flag.
//   imem_addr has no register of its own; it equals PC exactly (zero-latency combinational read).
// TESTING
//   1 Sequential: reset, imem at 0/2/4/6 = 1010,1231,145E,167F -> ifid_instr 1010,1231,145E,167F
//     on cycles 1-4, ifid_pc_plus 2,4,6,8, valid=1, imem_addr 0,2,4,6,8.
//   2 Stall: stall=1 for 2 cycles while PC=4 -> imem_addr stays 4, ifid holds 1231/pc_plus 4;
//     after release 145E registered next edge.
//   3 Branch vs stall: PC=6, branch_taken=1 target 16'h0021 with stall=1 -> PC=0020, ifid NOP,
//     valid=0; next edge fetches from 0020.
//   4 Halt: F000 at addr 8 -> ifid_instr F000 valid=1, halted=1, imem_addr stuck at 8, valid=0
//     thereafter; branch_taken target 0 -> halted=0, fetch resumes at 0.
//   5 Wrap: branch to FFFE, normal fetch -> ifid_pc_plus 0000, imem_addr 0000.
//   6 Async reset: assert rst=0 between edges mid-run -> all outputs reset immediately without clk;
//     release -> fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   IF stage of the 5-stage pipeline. Holds the PC, drives the instruction
//   memory read address and captures the returned 16-bit instruction into
//   the IF/ID pipeline register. Handles hazard stalls, branch redirects,
//   flushes and a HALT opcode that stops sequential fetch.
//
// Ports
//   clk            in   1   clock, all state changes on posedge
//   rst            in   1   asynchronous, active-low reset
//   stall          in   1   hold PC and IF/ID contents
//   flush          in   1   squash IF/ID to NOP_INSTR (PC still advances)
//   branch_taken   in   1   redirect PC to branch_target (bit 0 cleared)
//   branch_target  in   16  redirect address
//   imem_instr     in   16  instruction read combinationally at imem_addr
//   imem_addr      out  16  current PC (direct copy of PC register)
//   ifid_instr     out  16  registered instruction for decode
//   ifid_pc_plus   out  16  registered PC+PC_STEP of that instruction
//   ifid_valid     out  1   ifid_instr is a real fetched instruction
//   halted         out  1   fetch FSM is in HALT
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned PC_STEP   = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HALT_OP   = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_instr,
    output logic [15:0] imem_addr,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus,
    output logic        ifid_valid,
    output logic        halted
);

    localparam int unsigned XLEN  = 16;
    localparam int unsigned OP_LO = 12;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_next_seq;
    logic [XLEN-1:0]   redirect_pc;
    logic              is_halt_op;

    // Sequential successor wraps modulo 2^16 by construction.
    assign pc_next_seq = pc_q + XLEN'(PC_STEP);

    // Redirect targets are forced to instruction alignment.
    assign redirect_pc = {branch_target[XLEN-1:1], 1'b0};

    assign is_halt_op  = (imem_instr[XLEN-1:OP_LO] == HALT_OP);

    // Zero-latency read: the memory address is the PC itself.
    assign imem_addr   = pc_q;
    assign halted      = (state_q == ST_HALT);

    // Fetch FSM, PC and IF/ID register. Priority: branch > stall > flush > fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_instr   <= NOP_INSTR;
            ifid_pc_plus <= '0;
            ifid_valid   <= 1'b0;
        end else if (branch_taken) begin
            // Wrong-path squash; also the only way out of HALT.
            state_q    <= ST_RUN;
            pc_q       <= redirect_pc;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (stall) begin
            // Hold everything.
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush) begin
                        pc_q       <= pc_next_seq;
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end else begin
                        ifid_instr   <= imem_instr;
                        ifid_pc_plus <= pc_next_seq;
                        ifid_valid   <= 1'b1;
                        // HALT is still handed to decode, but the PC parks on it.
                        if (is_halt_op) begin
                            state_q <= ST_HALT;
                        end else begin
                            pc_q <= pc_next_seq;
                        end
                    end
                end
                ST_HALT: begin
                    // Emit bubbles until redirected or reset.
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage: directed scenarios followed by
//   randomized stall/flush/branch/reset traffic, all compared against a
//   behavioural model of the fetch rules and a 64K-word instruction memory.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_instr;
    logic [15:0] imem_addr;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus;
    logic        ifid_valid;
    logic        halted;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_instr    (imem_instr),
        .imem_addr     (imem_addr),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus  (ifid_pc_plus),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory, word per byte address (only even addresses used).
    logic [15:0] mem [0:65535];

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pp;
    logic        m_valid;
    logic        m_halt;

    int n_pass;
    int n_total;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},   32'(imem_addr),  32'(m_pc));
        check({tag, ".instr"},  32'(ifid_instr), 32'(m_instr));
        check({tag, ".valid"},  32'(ifid_valid), 32'(m_valid));
        check({tag, ".halted"}, 32'(halted),     32'(m_halt));
        if (m_valid) check({tag, ".pcplus"}, 32'(ifid_pc_plus), 32'(m_pp));
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp = 16'h0000;
        m_valid = 1'b0;  m_halt = 1'b0;
        check_all(tag);
        check({tag, ".pcplus0"}, 32'(ifid_pc_plus), 32'h0);
        #3;
        rst = 1'b1;
    endtask

    // One clock cycle: apply inputs, advance model by the fetch rules, compare.
    task automatic cyc(input logic s, input logic f, input logic b, input logic [15:0] t,
                       input string tag);
        logic [15:0] fetched;
        stall = s; flush = f; branch_taken = b; branch_target = t;
        imem_instr = mem[imem_addr];
        fetched = mem[m_pc];
        @(posedge clk);
        #1;
        if (b) begin
            m_pc = t & 16'hFFFE;
            m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (s) begin
            // nothing changes
        end else if (m_halt) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else if (f) begin
            m_pc = m_pc + 16'd2;
            m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = fetched; m_valid = 1'b1;
            m_pp = m_pc + 16'd2;
            if (fetched[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
        check_all(tag);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0000; imem_instr = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1010; mem[2] = 16'h1231; mem[4] = 16'h145E; mem[6] = 16'h167F;
        mem[8] = 16'hF000; mem[16'h20] = 16'h2222; mem[16'hFFFE] = 16'h1234;

        // Power-on reset.
        @(posedge clk); #1;
        do_reset("rst0");

        // Sequential fetch.
        cyc(0, 0, 0, 16'h0, "seq1");
        check("seq1.const", 32'(ifid_instr), 32'h1010);
        cyc(0, 0, 0, 16'h0, "seq2");
        check("seq2.const", 32'(ifid_pc_plus), 32'h0004);

        // Stall two cycles at PC=4.
        cyc(1, 0, 0, 16'h0, "stall1");
        cyc(1, 1, 0, 16'h0, "stall2");
        check("stall.addr", 32'(imem_addr), 32'h0004);
        check("stall.instr", 32'(ifid_instr), 32'h1231);
        cyc(0, 0, 0, 16'h0, "stall_rel");
        check("stall_rel.const", 32'(ifid_instr), 32'h145E);

        // Branch beats stall, odd target aligned.
        cyc(1, 1, 1, 16'h0021, "br_stall");
        check("br_stall.addr", 32'(imem_addr), 32'h0020);
        check("br_stall.valid", 32'(ifid_valid), 32'h0);
        cyc(0, 0, 0, 16'h0, "br_fetch");
        check("br_fetch.const", 32'(ifid_instr), 32'h2222);

        // Halt at address 8.
        cyc(0, 0, 1, 16'h0006, "to6");
        cyc(0, 0, 0, 16'h0, "f6");
        cyc(0, 0, 0, 16'h0, "f8");
        check("halt.instr", 32'(ifid_instr), 32'hF000);
        check("halt.valid", 32'(ifid_valid), 32'h1);
        check("halt.halted", 32'(halted), 32'h1);
        cyc(0, 0, 0, 16'h0, "halt_b1");
        cyc(0, 1, 0, 16'h0, "halt_fl");
        cyc(1, 0, 0, 16'h0, "halt_st");
        check("halt.addr", 32'(imem_addr), 32'h0008);
        check("halt.bubble", 32'(ifid_valid), 32'h0);
        cyc(0, 0, 1, 16'h0000, "halt_exit");
        check("halt_exit.halted", 32'(halted), 32'h0);
        cyc(0, 0, 0, 16'h0, "resume");
        check("resume.const", 32'(ifid_instr), 32'h1010);

        // PC wrap.
        cyc(0, 0, 1, 16'hFFFE, "to_fffe");
        cyc(0, 0, 0, 16'h0, "wrap");
        check("wrap.pcplus", 32'(ifid_pc_plus), 32'h0000);
        check("wrap.addr", 32'(imem_addr), 32'h0000);

        // Flush: bubble, PC advances.
        cyc(0, 1, 0, 16'h0, "flush");
        check("flush.addr", 32'(imem_addr), 32'h0002);

        // Async reset mid-run.
        cyc(0, 0, 0, 16'h0, "pre_rst");
        do_reset("rst_mid");
        cyc(0, 0, 0, 16'h0, "post_rst");
        check("post_rst.const", 32'(ifid_instr), 32'h1010);

        // Randomized traffic over a fully random memory.
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cyc(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0), 16'($urandom), "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
